dmem_sized: RTL
===============

Name: dmem_sized

Overview:
- Parametrised data memory for the MIPS datapath; successor to the flat word-only RAM.
- Accepts byte, halfword and word accesses for LB/LBU/LH/LHU/LW/SB/SH/SW. Handles lane steering and sign/zero extension, and flags misaligned accesses.
- Read data is registered, with a valid strobe.
- A post-reset clear sequencer zeroes the array in hardware, so no simulation-only initialisation is needed.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8, supported values 32 only in this revision.
- ADDR_WIDTH, 10, word-address width; depth = 2**ADDR_WIDTH words.
- BYTE_ADDR_W, ADDR_WIDTH+2, width of the byte address presented by the CPU.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  access request this cycle.
- req_ready  output  1  block can accept a request; 0 during clear.
- MemWrite  input  1  1 = store, 0 = load; sampled with req_valid.
- size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
- sign_ext  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  input  BYTE_ADDR_W  byte address.
- data_in  input  DATA_WIDTH  store data, right-aligned (bits [7:0] for byte).
- data_out  output  DATA_WIDTH  load result, extended.
- rvalid  output  1  one-cycle pulse; data_out is valid.
- err  output  1  one-cycle pulse; misaligned or reserved-size access.
- busy  output  1  clear sequence in progress.

Behaviour:
- One clock domain and one asynchronous active-low reset.
- Reset values: req_ready=0, busy=1, rvalid=0, err=0, data_out=0, clear counter=0, FSM=CLEAR.
- The array itself has no reset; it is cleared by the FSM.

FSM states:
- CLEAR: writes 0 to word[cnt] each cycle and increments cnt.
  - After the write at cnt=2**ADDR_WIDTH-1, go to IDLE.
  - Takes exactly 2**ADDR_WIDTH cycles after rst_n rises.
  - req_ready=0 and busy=1 throughout; requests are ignored.
- IDLE: req_ready=1, busy=0. Stays in IDLE permanently until the next reset.

Reset during CLEAR or IDLE:
- Returns to CLEAR with cnt=0.
- Any pending rvalid/err is dropped.

Accepted access:
- A request is accepted when req_valid && req_ready.
- Word index = addr[BYTE_ADDR_W-1:2]; lane = addr[1:0].
- Little-endian: byte lane k occupies bits [8k+7:8k].

Alignment check:
- halfword requires addr[0]=0; word requires addr[1:0]=00; size=11 is always an error.
- A failing access causes no write and no rvalid. err pulses the following cycle, and data_out is forced to 0 in that cycle.

Store:
- Byte: data_in[7:0] is written to lane addr[1:0].
- Halfword: data_in[15:0] is written to lanes {addr[1],0} and {addr[1],1}.
- Word: the full word is written.
- Unselected lanes are preserved (read-modify-write in the same cycle via per-byte enables).
- Stores never raise rvalid.

Load:
- Latency 1. The word is read at the accept edge; the lane is selected and extended.
- data_out is registered, and rvalid pulses on the next cycle.
- data_out holds its value until the next load or error.
- Extension:
  - byte: sign_ext ? {24{b[7]}} : 24'b0, concatenated with b.
  - halfword: same rule with 16 bits.
  - word: sign_ext is ignored.

Back-to-back accesses:
- One access per cycle, no bubble.
- A load in the cycle after a store to the same word returns the updated data (write-first on the registered read).

Decomposition:
- Package dmem_pkg contains:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_RSVD=2'b11;
  - FSM state encoding ST_CLEAR, ST_IDLE;
  - a function computing the 4-bit byte-enable from size and addr[1:0].
- One combinational sub-module, dmem_lane_align, handles:
  - store data replication and byte-enables;
  - load lane extraction and extension;
  - the misalignment flag.
- Storage, FSM and output registers stay in dmem_sized.

Test Plan:
1. Release rst_n and count cycles -> busy=1 and req_ready=0 for exactly 1024 cycles, then busy=0 and req_ready=1. A read of word 5 then returns 32'h0.
2. SW 0x8000_00F0 @0x10, then SB 0xAB @0x11, then LW @0x10 -> data_out=32'h8000_ABF0 with rvalid one cycle after the load is accepted.
3. LB @0x10 with sign_ext=1 -> 32'hFFFF_FFF0. LBU (sign_ext=0) -> 32'h0000_00F0. LH @0x12 with sign_ext=1 -> 32'hFFFF_8000. LHU -> 32'h0000_8000.
4. SH @0x13, LW @0x02, size=11 @0x00 -> err pulses once per access and rvalid=0. Memory at word 4 is unchanged (a following LW @0x10 returns 32'h8000_ABF0).
5. Back-to-back SW 0x1234_5678 @0x20 then LW @0x20 on consecutive cycles -> data_out=32'h1234_5678. Then assert rst_n=0 mid-stream for 1 cycle -> rvalid/err drop to 0, the FSM re-enters CLEAR, and a LW @0x20 after the clear returns 32'h0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the sized data memory.
// Size codes, clear-sequencer states and the byte-enable decoder.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } dmem_state_t;

   // Lanes touched by an access of the given size at the given byte offset.
   function automatic logic [3:0] be_calc(input logic [1:0] size, input logic [1:0] lane);
      logic [3:0] be;
      be = 4'b0000;
      case (size)
         SZ_BYTE: be = 4'b0001 << lane;
         SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store replication, byte enables,
// load lane extraction with sign/zero extension, and alignment check.
module dmem_lane_align
   import dmem_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [1:0]            i_size,
   input  logic [1:0]            i_lane,
   input  logic                  i_sign_ext,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [DATA_WIDTH-1:0] i_rword,
   output logic [3:0]            o_be,
   output logic [DATA_WIDTH-1:0] o_wdata,
   output logic [DATA_WIDTH-1:0] o_rdata,
   output logic                  o_misalign
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Store side: replicate narrow data across all lanes; enables pick the target.
   always_comb begin
      o_wdata = i_wdata;
      o_be    = be_calc(i_size, i_lane);
      case (i_size)
         SZ_BYTE: o_wdata = {4{i_wdata[7:0]}};
         SZ_HALF: o_wdata = {2{i_wdata[15:0]}};
         SZ_WORD: o_wdata = i_wdata;
         default: o_wdata = i_wdata;
      endcase
   end

   // Alignment: halfwords need an even offset, words a zero offset.
   always_comb begin
      o_misalign = 1'b1;
      case (i_size)
         SZ_BYTE: o_misalign = 1'b0;
         SZ_HALF: o_misalign = i_lane[0];
         SZ_WORD: o_misalign = (i_lane != 2'b00);
         default: o_misalign = 1'b1;
      endcase
   end

   // Load side: pick the addressed lane(s) and extend to a full word.
   always_comb begin
      w_byte  = i_rword[7:0];
      w_half  = i_rword[15:0];
      o_rdata = i_rword;
      case (i_lane)
         2'b00:   w_byte = i_rword[7:0];
         2'b01:   w_byte = i_rword[15:8];
         2'b10:   w_byte = i_rword[23:16];
         2'b11:   w_byte = i_rword[31:24];
         default: w_byte = i_rword[7:0];
      endcase
      if (i_lane[1]) begin
         w_half = i_rword[31:16];
      end else begin
         w_half = i_rword[15:0];
      end
      case (i_size)
         SZ_BYTE: o_rdata = {(i_sign_ext ? {24{w_byte[7]}} : 24'h000000), w_byte};
         SZ_HALF: o_rdata = {(i_sign_ext ? {16{w_half[15]}} : 16'h0000), w_half};
         SZ_WORD: o_rdata = i_rword;
         default: o_rdata = {DATA_WIDTH{1'b0}};
      endcase
   end

endmodule

// File: rtl/dmem_sized.sv
// Byte/half/word data memory with registered load data, error strobe
// and a post-reset hardware clear sequencer.
module dmem_sized
   import dmem_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 10,
   parameter int BYTE_ADDR_W = ADDR_WIDTH + 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   MemWrite,
   input  logic [1:0]             size,
   input  logic                   sign_ext,
   input  logic [BYTE_ADDR_W-1:0] addr,
   input  logic [DATA_WIDTH-1:0]  data_in,
   output logic [DATA_WIDTH-1:0]  data_out,
   output logic                   rvalid,
   output logic                   err,
   output logic                   busy
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

   dmem_state_t           r_state;
   dmem_state_t           w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic [ADDR_WIDTH-1:0] w_cnt_nxt;

   logic                  r_req_ready;
   logic                  r_busy;
   logic                  r_rvalid;
   logic                  r_err;
   logic [DATA_WIDTH-1:0] r_data_out;

   logic [ADDR_WIDTH-1:0] w_idx;
   logic [1:0]            w_lane;
   logic                  w_accept;
   logic                  w_store;
   logic                  w_load;
   logic                  w_bad;
   logic [3:0]            w_be;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic [DATA_WIDTH-1:0] w_rword;
   logic [DATA_WIDTH-1:0] w_rdata;
   logic                  w_misalign;

   assign w_idx    = addr[BYTE_ADDR_W-1:2];
   assign w_lane   = addr[1:0];
   assign w_accept = req_valid & (r_state == ST_IDLE);
   assign w_bad    = w_accept & w_misalign;
   assign w_store  = w_accept & MemWrite & ~w_misalign;
   assign w_load   = w_accept & ~MemWrite & ~w_misalign;
   assign w_rword  = r_mem[w_idx];

   dmem_lane_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_lane_align (
      .i_size     (size),
      .i_lane     (w_lane),
      .i_sign_ext (sign_ext),
      .i_wdata    (data_in),
      .i_rword    (w_rword),
      .o_be       (w_be),
      .o_wdata    (w_wdata),
      .o_rdata    (w_rdata),
      .o_misalign (w_misalign)
   );

   // Clear sequencer next-state: walk every word once, then idle until reset.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_CLEAR: begin
            w_cnt_nxt = r_cnt + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            if (r_cnt == {ADDR_WIDTH{1'b1}}) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_CLEAR;
            end
         end
         ST_IDLE: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = r_cnt;
         end
         default: begin
            w_state_nxt = ST_CLEAR;
            w_cnt_nxt   = {ADDR_WIDTH{1'b0}};
         end
      endcase
   end

   // State, counter and handshake/status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_CLEAR;
         r_cnt       <= {ADDR_WIDTH{1'b0}};
         r_req_ready <= 1'b0;
         r_busy      <= 1'b1;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_req_ready <= (w_state_nxt == ST_IDLE);
         r_busy      <= (w_state_nxt == ST_CLEAR);
      end
   end

   // Load result and strobes; data_out holds between loads and is zeroed on error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rvalid   <= 1'b0;
         r_err      <= 1'b0;
         r_data_out <= {DATA_WIDTH{1'b0}};
      end else begin
         r_rvalid <= w_load;
         r_err    <= w_bad;
         if (w_bad) begin
            r_data_out <= {DATA_WIDTH{1'b0}};
         end else if (w_load) begin
            r_data_out <= w_rdata;
         end else begin
            r_data_out <= r_data_out;
         end
      end
   end

   // Storage array: no reset, zeroed by the clear walk; stores use per-byte enables.
   always_ff @(posedge clk) begin
      if (r_state == ST_CLEAR) begin
         r_mem[r_cnt] <= {DATA_WIDTH{1'b0}};
      end else if (w_store) begin
         for (int k = 0; k < 4; k++) begin
            if (w_be[k]) begin
               r_mem[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
            end
         end
      end
   end

   assign req_ready = r_req_ready;
   assign busy      = r_busy;
   assign rvalid    = r_rvalid;
   assign err       = r_err;
   assign data_out  = r_data_out;

endmodule
